// File: rtl/line_arb_pkg.sv
// -----------------------------------------------------------------------------
// line_arb_pkg
// Shared types and defaults for the linedraw arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAITSTART, DRAW)
//   vec_t       : one line's endpoints at the default coordinate width
//   DEF_*       : default parameter values used by line_arbiter
// -----------------------------------------------------------------------------
package line_arb_pkg;

  localparam int DEF_NREQ          = 2;
  localparam int DEF_OUT_WIDTH     = 8;
  localparam int DEF_START_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAITSTART = 2'd2,
    DRAW      = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [DEF_OUT_WIDTH-1:0] stax;
    logic [DEF_OUT_WIDTH-1:0] stay;
    logic [DEF_OUT_WIDTH-1:0] endx;
    logic [DEF_OUT_WIDTH-1:0] endy;
  } vec_t;

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker. Scans last+1, last+2, ... modulo NREQ and
// returns the first pending index.
//   pending     in  NREQ   requesters waiting for the engine
//   last        in  OWN_W  index served most recently
//   grant       out OWN_W  chosen index (0 when nothing is pending)
//   any_pending out 1      at least one pending bit is set
// -----------------------------------------------------------------------------
module rr_select #(
  parameter int NREQ  = 2,
  parameter int OWN_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [OWN_W-1:0] last,
  output logic [OWN_W-1:0] grant,
  output logic             any_pending
);

  // Rotating priority scan; the first hit after 'last' wins.
  always_comb begin
    int               idx;
    logic [OWN_W-1:0] pos;
    grant       = {OWN_W{1'b0}};
    any_pending = 1'b0;
    idx         = 0;
    pos         = {OWN_W{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      pos = OWN_W'(idx);
      if (!any_pending && pending[pos]) begin
        grant       = pos;
        any_pending = 1'b1;
      end else begin
        any_pending = any_pending;
      end
    end
  end

endmodule

// File: rtl/line_arbiter.sv
// -----------------------------------------------------------------------------
// line_arbiter
// Shares one linedraw engine between NREQ vector sources. Each request's
// endpoints are latched into a per-requester slot, the engine is granted
// round-robin and the go/busy handshake is sequenced. 'owner' tags the
// requester whose pixels linedraw is currently producing.
//   clk, rst                      clock, synchronous active-high reset
//   req_go/req_stax..req_endy     per-requester request and packed endpoints
//   req_busy                      per-requester busy (pending bit)
//   ld_go, ld_stax..ld_endy       request to linedraw
//   ld_busy                       linedraw busy
//   owner, owner_vld              current grant tag
//   err_clr                       clears sticky error flags
//   err_overrun, err_timeout      sticky error flags
// -----------------------------------------------------------------------------
module line_arbiter
  import line_arb_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int OWN_W         = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_go,
  input  logic [NREQ*OUT_WIDTH-1:0] req_stax,
  input  logic [NREQ*OUT_WIDTH-1:0] req_stay,
  input  logic [NREQ*OUT_WIDTH-1:0] req_endx,
  input  logic [NREQ*OUT_WIDTH-1:0] req_endy,
  output logic [NREQ-1:0]           req_busy,
  output logic                      ld_go,
  output logic [OUT_WIDTH-1:0]      ld_stax,
  output logic [OUT_WIDTH-1:0]      ld_stay,
  output logic [OUT_WIDTH-1:0]      ld_endx,
  output logic [OUT_WIDTH-1:0]      ld_endy,
  input  logic                      ld_busy,
  output logic [OWN_W-1:0]          owner,
  output logic                      owner_vld,
  input  logic                      err_clr,
  output logic                      err_overrun,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] stax;
    logic [OUT_WIDTH-1:0] stay;
    logic [OUT_WIDTH-1:0] endx;
    logic [OUT_WIDTH-1:0] endy;
  } coord_t;

  arb_state_t       state;
  logic [NREQ-1:0]  pending;
  coord_t           slot [NREQ];
  logic [OWN_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [OWN_W-1:0] grant;
  logic             any_pending;
  logic             complete;
  logic             timeout_evt;
  logic             overrun_evt;
  logic [NREQ-1:0]  clr_mask;
  logic [NREQ-1:0]  capture;

  // The pending bits are registers, so busy appears the cycle after req_go.
  assign req_busy = pending;

  rr_select #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_rr (
    .pending     (pending),
    .last        (last),
    .grant       (grant),
    .any_pending (any_pending)
  );

  // Line completion: engine went idle in DRAW, or never started in WAITSTART.
  always_comb begin
    complete    = 1'b0;
    timeout_evt = 1'b0;
    cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    case (state)
      WAITSTART: begin
        if (!ld_busy && (cnt_inc == (CNT_W+1)'(START_TIMEOUT))) begin
          complete    = 1'b1;
          timeout_evt = 1'b1;
        end else begin
          complete    = 1'b0;
        end
      end
      DRAW: begin
        if (!ld_busy) begin
          complete = 1'b1;
        end else begin
          complete = 1'b0;
        end
      end
      default: begin
        complete = 1'b0;
      end
    endcase
  end

  // Capture vs overrun: a slot being released this cycle may be re-captured.
  always_comb begin
    clr_mask = {NREQ{1'b0}};
    capture  = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      clr_mask[i] = complete && (owner == OWN_W'(i));
      capture[i]  = req_go[i] && (!pending[i] || clr_mask[i]);
    end
    overrun_evt = |(req_go & pending & ~clr_mask);
  end

  // Slot capture, grant sequencing and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= {NREQ{1'b0}};
      last        <= OWN_W'(NREQ - 1);
      cnt         <= {CNT_W{1'b0}};
      owner       <= {OWN_W{1'b0}};
      owner_vld   <= 1'b0;
      ld_go       <= 1'b0;
      ld_stax     <= {OUT_WIDTH{1'b0}};
      ld_stay     <= {OUT_WIDTH{1'b0}};
      ld_endx     <= {OUT_WIDTH{1'b0}};
      ld_endy     <= {OUT_WIDTH{1'b0}};
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      pending     <= (pending & ~clr_mask) | capture;
      err_overrun <= (err_overrun & ~err_clr) | overrun_evt;
      err_timeout <= (err_timeout & ~err_clr) | timeout_evt;
      ld_go       <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (capture[i]) begin
          slot[i].stax <= req_stax[i*OUT_WIDTH +: OUT_WIDTH];
          slot[i].stay <= req_stay[i*OUT_WIDTH +: OUT_WIDTH];
          slot[i].endx <= req_endx[i*OUT_WIDTH +: OUT_WIDTH];
          slot[i].endy <= req_endy[i*OUT_WIDTH +: OUT_WIDTH];
        end
      end

      case (state)
        IDLE: begin
          if (any_pending) begin
            // ld_go is raised here so it is high during the ISSUE cycle.
            owner     <= grant;
            owner_vld <= 1'b1;
            ld_go     <= 1'b1;
            ld_stax   <= slot[grant].stax;
            ld_stay   <= slot[grant].stay;
            ld_endx   <= slot[grant].endx;
            ld_endy   <= slot[grant].endy;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= {CNT_W{1'b0}};
          state <= WAITSTART;
        end
        WAITSTART: begin
          if (ld_busy) begin
            state <= DRAW;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
        DRAW: begin
          state <= DRAW;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Completion overrides the per-state transition above.
      if (complete) begin
        last      <= owner;
        owner_vld <= 1'b0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_arbiter
// Directed bench for line_arbiter with NREQ=2, OUT_WIDTH=8, START_TIMEOUT=15.
// A small linedraw stand-in raises ld_busy the cycle after ld_go and drops it
// four cycles later; it can be disabled to provoke a start timeout.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_line_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_go;
  logic [NREQ*W-1:0] req_stax, req_stay, req_endx, req_endy;
  logic [NREQ-1:0] req_busy;
  logic            ld_go;
  logic [W-1:0]    ld_stax, ld_stay, ld_endx, ld_endy;
  logic            ld_busy;
  logic            owner;
  logic            owner_vld;
  logic            err_clr;
  logic            err_overrun, err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  bit stub_en;
  int stub_cnt;
  int extra;

  always #5 clk = ~clk;

  line_arbiter #(.NREQ(NREQ), .OUT_WIDTH(W), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_go(req_go),
    .req_stax(req_stax), .req_stay(req_stay), .req_endx(req_endx), .req_endy(req_endy),
    .req_busy(req_busy), .ld_go(ld_go),
    .ld_stax(ld_stax), .ld_stay(ld_stay), .ld_endx(ld_endx), .ld_endy(ld_endy),
    .ld_busy(ld_busy), .owner(owner), .owner_vld(owner_vld),
    .err_clr(err_clr), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  // Linedraw stand-in: busy for cycles L+1..L+4 after ld_go at cycle L.
  always @(posedge clk) begin
    if (rst || !stub_en) begin
      ld_busy  <= 1'b0;
      stub_cnt <= 0;
    end else if (ld_go) begin
      ld_busy  <= 1'b1;
      stub_cnt <= 3;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end else begin
      ld_busy  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] sx, input logic [W-1:0] sy,
                         input logic [W-1:0] ex, input logic [W-1:0] ey);
    req_stax[i*W +: W] = sx;
    req_stay[i*W +: W] = sy;
    req_endx[i*W +: W] = ex;
    req_endy[i*W +: W] = ey;
  endtask

  task automatic wait_ld_go(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (ld_go === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (req_busy === 2'b00 && owner_vld === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_busy_low(input int r, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (req_busy[r] === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_ld_busy(input logic lvl, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (ld_busy === lvl) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic count_extra_go();
    extra = 0;
    repeat (12) begin
      if (ld_go === 1'b1) extra++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; req_go = '0; err_clr = 1'b0; stub_en = 1'b1;
    req_stax = '0; req_stay = '0; req_endx = '0; req_endy = '0;
    step(); step();
    // Reset state
    check("rst_req_busy", 32'(req_busy), 32'd0);
    check("rst_ld_go", 32'(ld_go), 32'd0);
    check("rst_owner_vld", 32'(owner_vld), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_err_ovr", 32'(err_overrun), 32'd0);
    check("rst_err_to", 32'(err_timeout), 32'd0);
    check("rst_ld_endx", 32'(ld_endx), 32'd0);
    rst = 1'b0;
    step();

    // Simultaneous requests: 0 first (fresh pointer), then 1, inputs scrambled after capture
    set_req(0, 8'd150, 8'd90, 8'd0, 8'd0);
    set_req(1, 8'd254, 8'd1, 8'd255, 8'd254);
    req_go = 2'b11;
    step();
    req_go = 2'b00;
    set_req(0, 8'd9, 8'd9, 8'd9, 8'd9);
    set_req(1, 8'd7, 8'd7, 8'd7, 8'd7);
    check("sim_busy", 32'(req_busy), 32'd3);
    wait_ld_go("sim_go0");
    check("sim0_owner", 32'(owner), 32'd0);
    check("sim0_stax", 32'(ld_stax), 32'd150);
    check("sim0_stay", 32'(ld_stay), 32'd90);
    check("sim0_endx", 32'(ld_endx), 32'd0);
    check("sim0_endy", 32'(ld_endy), 32'd0);
    step();
    wait_ld_go("sim_go1");
    check("sim1_owner", 32'(owner), 32'd1);
    check("sim1_stax", 32'(ld_stax), 32'd254);
    check("sim1_stay", 32'(ld_stay), 32'd1);
    check("sim1_endx", 32'(ld_endx), 32'd255);
    check("sim1_endy", 32'(ld_endy), 32'd254);
    step();
    wait_idle("sim_idle");
    count_extra_go();
    check("sim_extra_go", 32'(extra), 32'd0);

    // Fairness: each owner re-requests as soon as its busy falls
    req_go = 2'b11;
    step();
    req_go = 2'b00;
    for (int ln = 0; ln < 6; ln++) begin
      wait_ld_go("fair_go");
      check("fair_owner", 32'(owner), 32'(ln % 2));
      wait_busy_low(ln % 2, "fair_busy_low");
      if (ln < 4) begin
        req_go[ln % 2] = 1'b1;
        step();
        req_go = 2'b00;
      end
    end
    wait_idle("fair_idle");
    count_extra_go();
    check("fair_extra_go", 32'(extra), 32'd0);
    check("fair_no_ovr", 32'(err_overrun), 32'd0);

    // Single request: busy at t+1, ld_go at t+2, busy falls one after ld_busy
    set_req(0, 8'd0, 8'd0, 8'd200, 8'd200);
    req_go = 2'b01;
    step();
    req_go = 2'b00;
    check("one_busy_t1", 32'(req_busy), 32'd1);
    check("one_go_t1", 32'(ld_go), 32'd0);
    step();
    check("one_go_t2", 32'(ld_go), 32'd1);
    check("one_owner", 32'(owner), 32'd0);
    check("one_owner_vld", 32'(owner_vld), 32'd1);
    check("one_stax", 32'(ld_stax), 32'd0);
    check("one_endx", 32'(ld_endx), 32'd200);
    check("one_endy", 32'(ld_endy), 32'd200);
    step();
    check("one_go_t3", 32'(ld_go), 32'd0);
    repeat (4) step();
    check("one_busy_t7", 32'(req_busy), 32'd1);
    check("one_vld_t7", 32'(owner_vld), 32'd1);
    step();
    check("one_busy_t8", 32'(req_busy), 32'd0);
    check("one_vld_t8", 32'(owner_vld), 32'd0);
    check("one_hold_endx", 32'(ld_endx), 32'd200);

    // Overrun: second req_go[1] while pending is dropped
    set_req(1, 8'd5, 8'd6, 8'd7, 8'd8);
    req_go = 2'b10;
    step();
    set_req(1, 8'd10, 8'd20, 8'd0, 8'd0);
    step();
    req_go = 2'b00;
    check("ovr_flag", 32'(err_overrun), 32'd1);
    check("ovr_go", 32'(ld_go), 32'd1);
    check("ovr_owner", 32'(owner), 32'd1);
    check("ovr_stax", 32'(ld_stax), 32'd5);
    check("ovr_stay", 32'(ld_stay), 32'd6);
    check("ovr_endx", 32'(ld_endx), 32'd7);
    check("ovr_endy", 32'(ld_endy), 32'd8);
    step();
    check("ovr_sticky", 32'(err_overrun), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_cleared", 32'(err_overrun), 32'd0);
    // Re-request in the very cycle the line completes: a fresh capture
    wait_ld_busy(1'b0, "reuse_wait");
    set_req(1, 8'd33, 8'd44, 8'd55, 8'd66);
    req_go = 2'b10;
    step();
    req_go = 2'b00;
    check("reuse_busy", 32'(req_busy), 32'd2);
    check("reuse_no_ovr", 32'(err_overrun), 32'd0);
    wait_ld_go("reuse_go");
    check("reuse_owner", 32'(owner), 32'd1);
    check("reuse_stax", 32'(ld_stax), 32'd33);
    check("reuse_endy", 32'(ld_endy), 32'd66);
    step();
    wait_idle("reuse_idle");

    // Timeout: engine never starts; flag at ld_go + 16, next requester served
    stub_en = 1'b0;
    set_req(0, 8'd1, 8'd2, 8'd3, 8'd4);
    set_req(1, 8'd11, 8'd12, 8'd13, 8'd14);
    req_go = 2'b11;
    step();
    req_go = 2'b00;
    wait_ld_go("to_go");
    check("to_owner0", 32'(owner), 32'd0);
    repeat (TO) step();
    check("to_not_yet", 32'(err_timeout), 32'd0);
    check("to_busy_before", 32'(req_busy), 32'd3);
    step();
    check("to_flag", 32'(err_timeout), 32'd1);
    check("to_busy_after", 32'(req_busy), 32'd2);
    check("to_vld_after", 32'(owner_vld), 32'd0);
    stub_en = 1'b1;
    wait_ld_go("to_next_go");
    check("to_owner1", 32'(owner), 32'd1);
    check("to_next_stax", 32'(ld_stax), 32'd11);
    step();
    wait_idle("to_idle");
    check("to_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_cleared", 32'(err_timeout), 32'd0);

    // Reset in the middle of a draw
    set_req(0, 8'd40, 8'd50, 8'd60, 8'd70);
    req_go = 2'b01;
    step();
    req_go = 2'b00;
    wait_ld_go("rd_go");
    step(); step();
    check("rd_in_draw", 32'(ld_busy), 32'd1);
    rst = 1'b1;
    step();
    check("rd_vld", 32'(owner_vld), 32'd0);
    check("rd_busy", 32'(req_busy), 32'd0);
    check("rd_go0", 32'(ld_go), 32'd0);
    check("rd_stax", 32'(ld_stax), 32'd0);
    check("rd_endy", 32'(ld_endy), 32'd0);
    rst = 1'b0;
    step();
    check("rd_no_go", 32'(ld_go), 32'd0);
    set_req(0, 8'd80, 8'd81, 8'd82, 8'd83);
    req_go = 2'b01;
    step();
    req_go = 2'b00;
    wait_ld_go("rd_new_go");
    check("rd_new_owner", 32'(owner), 32'd0);
    check("rd_new_stax", 32'(ld_stax), 32'd80);
    check("rd_new_endy", 32'(ld_endy), 32'd83);
    step();
    wait_idle("rd_new_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/line_arbiter.md
Name: line_arbiter

Overview:
- Shares one linedraw engine between NREQ vector sources, e.g. a radar-sweep display list and a target/symbol display list, each driven by its own vector_manage instance.
- Each requester sees a linedraw-compatible go/busy interface.
- The arbiter latches each request's endpoints, grants the engine round-robin and sequences the go/busy handshake.
- It tags the active owner so the framebuffer write path can route or colour the pixels.

Parameters:
- NREQ, 2, number of requesters (2..4).
- OUT_WIDTH, 8, coordinate width.
- START_TIMEOUT, 15, max cycles to wait for ld_busy to rise after ld_go.
- OWN_W, $clog2(NREQ), owner index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_go  in  NREQ  per-requester one-cycle draw request.
- req_stax  in  NREQ*OUT_WIDTH  start x, packed, requester i at [i*OUT_WIDTH +: OUT_WIDTH].
- req_stay  in  NREQ*OUT_WIDTH  start y.
- req_endx  in  NREQ*OUT_WIDTH  end x.
- req_endy  in  NREQ*OUT_WIDTH  end y.
- req_busy  out  NREQ  per-requester busy; high from the cycle after req_go until that line completes.
- ld_go  out  1  go pulse to linedraw.
- ld_stax, ld_stay, ld_endx, ld_endy  out  OUT_WIDTH each  coordinates to linedraw.
- ld_busy  in  1  linedraw busy.
- owner  out  OWN_W  index of the requester currently granted; valid while owner_vld.
- owner_vld  out  1  high in ISSUE, WAITSTART and DRAW.
- err_clr  in  1  clears the sticky error flags.
- err_overrun  out  1  sticky: req_go arrived while that requester was already pending or active.
- err_timeout  out  1  sticky: ld_busy failed to rise within START_TIMEOUT.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs 0, all pending bits 0, state IDLE.
  - Round-robin pointer last = NREQ-1, so requester 0 has priority first.
- Capture:
  - req_go[i]=1 with pending[i]=0 sets pending[i] and latches requester i's four coordinates into slot i at that edge.
  - req_busy[i] = pending[i], registered, so it is high at t+1 after req_go at t.
- Overrun: req_go[i]=1 while pending[i]=1 leaves slot i and its coordinates unchanged and sets err_overrun.
- Simultaneous req_go from several requesters: all are captured in the same cycle.
- FSM states: IDLE, ISSUE, WAITSTART, DRAW.
- IDLE:
  - If any pending bit is set, pick g = the first pending index scanning last+1, last+2, … modulo NREQ.
  - Register owner=g and drive ld_* from slot g, then go to ISSUE.
  - Best-case latency is ld_go at t+2 after req_go at t.
- ISSUE:
  - ld_go=1 for exactly one cycle.
  - Load the timeout counter with 0, then go to WAITSTART.
- WAITSTART:
  - ld_busy=1 goes to DRAW.
  - Otherwise increment the counter. When counter == START_TIMEOUT, set err_timeout and go to COMPLETE handling (below).
- DRAW: when ld_busy=0, go to COMPLETE handling.
- COMPLETE handling (same edge as the exit from WAITSTART or DRAW):
  - Clear pending[owner], set last=owner, owner_vld=0, state IDLE.
  - req_busy[owner] falls one cycle after ld_busy falls.
- ld_stax/stay/endx/endy hold their values from the IDLE decision through DRAW and keep their last value in IDLE.
- A completing requester may re-request in the cycle its busy falls. Round robin then serves any other pending requester first.
- A req_go[i] arriving in the same cycle pending[i] clears is a new capture, not an overrun.
- err_clr clears both sticky flags. If err_clr and a new error event coincide, the error wins.
- rst mid-DRAW aborts immediately. ld_go stays 0. The linedraw instance must be reset by the same rst.
- owner_vld=0 in IDLE. Pixel writes (wr) from linedraw are attributable to owner only while owner_vld=1.

Decomposition:
- Package line_arb_pkg contains:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAITSTART, DRAW}.
  - typedef struct packed vec_t {stax, stay, endx, endy}, each OUT_WIDTH.
  - Localparam for the default START_TIMEOUT.
- One sub-module, rr_select: a combinational round-robin picker taking the pending vector and last, producing grant index and any_pending.

Test Plan:
- Single request: req_go[0] at cycle 10 with (0,0)->(200,200) -> req_busy[0]=1 at cycle 11, ld_go=1 at cycle 12, owner=0, ld coordinates equal the request, req_busy[0] falls one cycle after ld_busy falls.
- Simultaneous: req_go[0] (150,90)->(0,0) and req_go[1] (254,1)->(255,254) in the same cycle -> requester 0 is drawn first, then 1, exactly two ld_go pulses, coordinates unchanged.
- Fairness: both requesters re-request immediately on each completion for 6 lines -> owner sequence 0,1,0,1,0,1.
- Overrun: second req_go[1] with (10,20)->(0,0) while pending -> err_overrun=1, and the line drawn is the first request's; err_clr -> flag returns to 0.
- Timeout: stub ld_busy tied 0 -> err_timeout set exactly START_TIMEOUT+1 cycles after ld_go, pending cleared, next requester served.
- Reset mid-DRAW: assert rst during DRAW -> next cycle state IDLE and all outputs 0; a new request afterwards draws normally.
